// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg
// Shared definitions for the instruction issue controller: the CPU ISA
// opcode constants, the issue FSM state encoding, the packed queue entry
// width and a helper that classifies multi-cycle (long) operations.
package issue_ctrl_pkg;

  // ISA opcodes (4-bit). 0100..0111 are all NOP.
  localparam logic [3:0] OP_MVR = 4'b0000;
  localparam logic [3:0] OP_LDB = 4'b0001;
  localparam logic [3:0] OP_STB = 4'b0010;
  localparam logic [3:0] OP_RDS = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_ADD = 4'b1011;
  localparam logic [3:0] OP_SUB = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;
  localparam logic [3:0] OP_MUL = 4'b1111;

  // Queue entry = {op, r1, b}
  localparam int INSTR_W = 16;

  // Issue FSM: IDLE may issue, LONG blocks issue while the datapath is occupied
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LONG = 1'b1
  } state_t;

  // Only MUL occupies the datapath for more than one cycle
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo
// In-order instruction queue with synchronous flush. The head entry is
// presented combinationally on dout so a pop consumes it in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write request and entry (refused when full or flushing)
//   pop             consume head (ignored when empty)
//   flush           discard all entries this cycle
//   dout            head entry
//   count           registered occupancy
//   empty           count == 0
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [4:0]       count,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == 5'(DEPTH));
  assign empty = (count == 5'd0);
  assign dout  = mem[rd_ptr];

  // Full check uses the registered count, so a same-cycle pop never frees a slot
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + 5'(do_push) - 5'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl
// Single-issue, in-order instruction issue controller. Instructions are
// queued in issue_fifo and issued one per cycle; a MUL blocks further issue
// for LONG_CYCLES cycles while it occupies the datapath.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         producer handshake; in_op/in_r1/in_b fields
//   flush                     discard queued, not-yet-issued instructions
//   iss_valid                 one-cycle issue pulse; iss_op/iss_r1/iss_b held
//   busy                      long op occupies the datapath
//   long_done                 pulse on the last occupancy cycle of a long op
//   q_count                   queue occupancy
// Optional feature macro ISSUE_CTRL_PERF_EN adds perf_issued and perf_stall,
// 8-bit saturating event counters.
import issue_ctrl_pkg::*;

module issue_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LONG_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [3:0] in_r1,
  input  logic [7:0] in_b,
  input  logic       flush,
  output logic       iss_valid,
  output logic [3:0] iss_op,
  output logic [3:0] iss_r1,
  output logic [7:0] iss_b,
  output logic       busy,
  output logic       long_done,
  output logic [4:0] q_count
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [7:0] perf_issued,
  output logic [7:0] perf_stall
`endif
);

  state_t             state;
  logic [3:0]         cnt;
  logic [INSTR_W-1:0] head;
  logic               empty;
  logic               push;
  logic               pop;

  assign in_ready = (q_count < 5'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == ST_IDLE) & ~empty;

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({in_op, in_r1, in_b}),
    .dout  (head),
    .count (q_count),
    .empty (empty)
  );

  // Issue FSM. long_done is raised one edge early (cnt == 1) so that, being
  // registered, it lands on the cycle where cnt reaches 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      iss_valid <= 1'b0;
      iss_op    <= 4'd0;
      iss_r1    <= 4'd0;
      iss_b     <= 8'd0;
      busy      <= 1'b0;
      long_done <= 1'b0;
    end else begin
      iss_valid <= pop;
      long_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            iss_op <= head[15:12];
            iss_r1 <= head[11:8];
            iss_b  <= head[7:0];
            if (is_long_op(head[15:12])) begin
              state <= ST_LONG;
              cnt   <= 4'(LONG_CYCLES - 1);
              busy  <= 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt       <= cnt - 4'd1;
            long_done <= (cnt == 4'd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  // Saturating counters: issue pulses, and LONG cycles with work waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= 8'd0;
      perf_stall  <= 8'd0;
    end else begin
      if (iss_valid && perf_issued != 8'hFF)
        perf_issued <= perf_issued + 8'd1;
      if (state == ST_LONG && !empty && perf_stall != 8'hFF)
        perf_stall <= perf_stall + 8'd1;
    end
  end
`endif

endmodule
